mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses that meet at the memory port arbiter:
//   cpu_*  : CPU datapath request/ack handshake, read data and stall
//   ext_*  : external (loader / debug host) request/ack handshake, read data
//   mem_*  : strobes, address and data towards the unified memory
//   busy   : arbiter is in the middle of an access
// Modports:
//   master : the surroundings (requesters and memory) that drive the requests
//            and mem_rdata and observe the arbiter outputs
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one unified memory between the CPU datapath and an external port.
// Accesses are serialised through IDLE -> ISSUE -> (WAIT) -> DONE; when both
// ports request in the same IDLE cycle the one that was not granted last wins.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave view of mem_port_arbiter_if (cpu_*, ext_*, mem_*, busy)
// Parameters:
//   ADDR_W, DATA_W : address / data width
//   RD_LAT         : cycles from the mem_read cycle to valid mem_rdata (>= 1)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {CPU = 1'b0, EXT = 1'b1} port_t;

  state_t            state_reg, state_next;
  port_t             owner_reg, owner_next;
  port_t             last_grant_reg, last_grant_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0] ext_rdata_reg, ext_rdata_next;

  logic  grant_valid;
  port_t grant_port;

  // Round-robin pick: on a tie the port that did not win last time is served.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = CPU;
    if (bus.cpu_req && bus.ext_req) begin
      grant_valid = 1'b1;
      grant_port  = (last_grant_reg == CPU) ? EXT : CPU;
    end else if (bus.cpu_req) begin
      grant_valid = 1'b1;
      grant_port  = CPU;
    end else if (bus.ext_req) begin
      grant_valid = 1'b1;
      grant_port  = EXT;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    cnt_next        = cnt_reg;
    cpu_rdata_next  = cpu_rdata_reg;
    ext_rdata_next  = ext_rdata_reg;

    unique case (state_reg)
      IDLE: begin
        // Requests are only looked at here, so the access in flight is
        // immune to anything the requesters do until it completes.
        if (grant_valid) begin
          owner_next      = grant_port;
          last_grant_next = grant_port;
          if (grant_port == CPU) begin
            we_next    = bus.cpu_we;
            addr_next  = bus.cpu_addr;
            wdata_next = bus.cpu_wdata;
          end else begin
            we_next    = bus.ext_we;
            addr_next  = bus.ext_addr;
            wdata_next = bus.ext_wdata;
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = DONE;
        end else begin
          cnt_next   = CNT_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        // Count of 1 marks the cycle in which mem_rdata is valid.
        if (cnt_reg == CNT_ONE) begin
          if (owner_reg == CPU) cpu_rdata_next = bus.mem_rdata;
          else                  ext_rdata_next = bus.mem_rdata;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      owner_reg      <= CPU;
      last_grant_reg <= EXT;   // CPU wins the first tie after reset
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      cpu_rdata_reg  <= '0;
      ext_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      cnt_reg        <= cnt_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      ext_rdata_reg  <= ext_rdata_next;
    end
  end

  // Strobes and acks decode straight from the state register so they drop
  // the moment reset_n goes low.
  assign bus.mem_read  = (state_reg == ISSUE) && !we_reg;
  assign bus.mem_write = (state_reg == ISSUE) &&  we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign bus.cpu_ack   = (state_reg == DONE) && (owner_reg == CPU);
  assign bus.ext_ack   = (state_reg == DONE) && (owner_reg == EXT);
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.ext_rdata = ext_rdata_reg;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives two arbiter instances (RD_LAT=1 and RD_LAT=3) against a behavioural
// memory whose read data is only valid in the single cycle it should be
// sampled. Expected transactions are queued when a request is driven and
// popped when the matching ack appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int RD_LAT  = 1;
  localparam int RD_LAT3 = 3;
  localparam logic [DATA_W-1:0] POISON = 16'h0BAD;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT3)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(bus3)
  );

  // ---------------- behavioural memory ----------------
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] pipe1 [RD_LAT];
  logic [DATA_W-1:0] pipe3 [RD_LAT3];
  logic              mem_ready = 1'b0;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    case (i)
      16'h0010: return 16'hBEEF;
      16'h0011: return 16'hCAFE;
      16'h0001: return 16'hA5A5;
      default:  return {~b, b};
    endcase
  endfunction

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    pipe1[0] <= bus.mem_read ? mem[bus.mem_addr[7:0]] : POISON;
    for (int i = 1; i < RD_LAT; i++) pipe1[i] <= pipe1[i-1];
    pipe3[0] <= bus3.mem_read ? mem[bus3.mem_addr[7:0]] : POISON;
    for (int i = 1; i < RD_LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign bus.mem_rdata  = pipe1[RD_LAT-1];
  assign bus3.mem_rdata = pipe3[RD_LAT3-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic              port;   // 0 = CPU, 1 = EXT
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;   // read: expected rdata, write: written data
  } txn_t;
  txn_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic drive_cpu(input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic drive_ext(input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.ext_req = req; bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata;
  endtask

  // Advances until an ack appears on the RD_LAT=1 instance.
  // who: 0 CPU, 1 EXT, 2 both at once, 3 none within the budget.
  task automatic wait_ack(output int who, output int edges);
    who = 3;
    edges = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      edges++;
      if (bus.cpu_ack && bus.ext_ack) begin who = 2; return; end
      if (bus.cpu_ack) begin who = 0; return; end
      if (bus.ext_ack) begin who = 1; return; end
    end
  endtask

  task automatic show_txn(input txn_t t, input int edges);
    $display("%0t txn %s %s addr=%h data=%h edges=%0d", $time,
             t.port ? "EXT" : "CPU", t.we ? "WR" : "RD", t.addr, t.data, edges);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int who, edges;
    txn_t t;
    reset_n = 1'b0;
    drive_cpu(0, 0, '0, '0);
    drive_ext(0, 0, '0, '0);
    repeat (3) @(posedge clock); #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if ({bus.mem_read, bus.mem_write, bus.cpu_ack, bus.ext_ack} !== 4'b0)
      $display("FAIL rst_strobes: got %b want 0000", {bus.mem_read, bus.mem_write, bus.cpu_ack, bus.ext_ack}); else pass_cnt++;
    total_cnt++; if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ext_rdata} !== 64'h0)
      $display("FAIL rst_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.ext_rdata}); else pass_cnt++;
    total_cnt++; if (bus.cpu_stall !== 1'b0) $display("FAIL rst_stall_lo: got %b want 0", bus.cpu_stall); else pass_cnt++;
    bus.cpu_req = 1'b1; #1;
    total_cnt++; if (bus.cpu_stall !== 1'b1) $display("FAIL rst_stall_hi: got %b want 1", bus.cpu_stall); else pass_cnt++;
    bus.cpu_req = 1'b0;

    // Start an external write, then pull reset while it is strobed.
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive_ext(1, 1, 16'h0005, 16'h5555);
    @(posedge clock); #1;
    total_cnt++; if (bus.mem_write !== 1'b1) $display("FAIL mid_issue_write: got %b want 1", bus.mem_write); else pass_cnt++;
    reset_n = 1'b0; #1;
    total_cnt++; if ({bus.mem_write, bus.busy, bus.ext_ack} !== 3'b000)
      $display("FAIL mid_reset_outputs: got %b want 000", {bus.mem_write, bus.busy, bus.ext_ack}); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 16'h0000) $display("FAIL mid_reset_addr: got %h want 0000", bus.mem_addr); else pass_cnt++;
    drive_ext(0, 0, '0, '0);
    total_cnt++; if (mem[5] !== 16'hFA05) $display("FAIL aborted_write_mem: got %h want fa05", mem[5]); else pass_cnt++;

    // Release reset with a CPU read already pending.
    drive_cpu(1, 0, 16'h0010, '0);
    exp_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0010, data: 16'hBEEF});
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    total_cnt++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, 16'h0010})
      $display("FAIL first_read_issue: got %b/%h want 1/0010", bus.mem_read, bus.mem_addr); else pass_cnt++;
    wait_ack(who, edges);
    t = exp_q.pop_front();
    show_txn(t, edges + 1);
    total_cnt++; if (who !== int'(t.port)) $display("FAIL first_read_port: got %0d want %0d", who, t.port); else pass_cnt++;
    total_cnt++; if (edges + 1 !== 2 + RD_LAT) $display("FAIL first_read_lat: got %0d want %0d", edges + 1, 2 + RD_LAT); else pass_cnt++;
    total_cnt++; if (bus.cpu_rdata !== t.data) $display("FAIL first_read_data: got %h want %h", bus.cpu_rdata, t.data); else pass_cnt++;
    total_cnt++; if (bus.cpu_stall !== 1'b0) $display("FAIL first_read_stall_at_ack: got %b want 0", bus.cpu_stall); else pass_cnt++;
    drive_cpu(0, 0, '0, '0);
    @(posedge clock); #1;
    total_cnt++; if ({bus.cpu_ack, bus.busy} !== 2'b00) $display("FAIL first_read_after: got %b want 00", {bus.cpu_ack, bus.busy}); else pass_cnt++;
  endtask

  task automatic test_ext_write();
    int who, edges;
    txn_t t;
    drive_ext(1, 1, 16'h0042, 16'h1234);
    exp_q.push_back('{port: 1'b1, we: 1'b1, addr: 16'h0042, data: 16'h1234});
    @(posedge clock); #1;
    total_cnt++; if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata} !== {2'b10, 16'h0042, 16'h1234})
      $display("FAIL ext_wr_issue: got %b%b %h %h want 10 0042 1234", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    wait_ack(who, edges);
    t = exp_q.pop_front();
    show_txn(t, edges + 1);
    total_cnt++; if (who !== int'(t.port)) $display("FAIL ext_wr_port: got %0d want %0d", who, t.port); else pass_cnt++;
    total_cnt++; if (edges + 1 !== 2) $display("FAIL ext_wr_lat: got %0d want 2", edges + 1); else pass_cnt++;
    total_cnt++; if (bus.mem_write !== 1'b0) $display("FAIL ext_wr_strobe_len: got %b want 0", bus.mem_write); else pass_cnt++;
    total_cnt++; if (mem[t.addr[7:0]] !== t.data) $display("FAIL ext_wr_mem: got %h want %h", mem[t.addr[7:0]], t.data); else pass_cnt++;
    total_cnt++; if ({bus.cpu_rdata, bus.ext_rdata} !== {16'hBEEF, 16'h0000})
      $display("FAIL ext_wr_rdata_kept: got %h %h want beef 0000", bus.cpu_rdata, bus.ext_rdata); else pass_cnt++;
    drive_ext(0, 0, '0, '0);
    @(posedge clock); #1;
  endtask

  task automatic test_contention();
    int who, edges;
    txn_t t;
    logic [DATA_W-1:0] got;
    drive_cpu(1, 0, 16'h0010, '0);
    drive_ext(1, 0, 16'h0042, '0);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0010, data: 16'hBEEF});
      exp_q.push_back('{port: 1'b1, we: 1'b0, addr: 16'h0042, data: 16'h1234});
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, edges);
      if (k == 3) begin
        drive_cpu(0, 0, '0, '0);
        drive_ext(0, 0, '0, '0);
      end
      t = exp_q.pop_front();
      show_txn(t, edges);
      got = t.port ? bus.ext_rdata : bus.cpu_rdata;
      total_cnt++; if (who !== int'(t.port)) $display("FAIL contention_order%0d: got %0d want %0d", k, who, t.port); else pass_cnt++;
      total_cnt++; if (edges !== ((k == 0) ? 2 + RD_LAT : 3 + RD_LAT))
        $display("FAIL contention_spacing%0d: got %0d want %0d", k, edges, (k == 0) ? 2 + RD_LAT : 3 + RD_LAT); else pass_cnt++;
      total_cnt++; if (got !== t.data) $display("FAIL contention_data%0d: got %h want %h", k, got, t.data); else pass_cnt++;
    end
    @(posedge clock); #1;
    total_cnt++; if ({bus.cpu_ack, bus.ext_ack, bus.busy} !== 3'b000)
      $display("FAIL contention_after: got %b want 000", {bus.cpu_ack, bus.ext_ack, bus.busy}); else pass_cnt++;
  endtask

  task automatic test_stall();
    int who, edges;
    txn_t t;
    drive_ext(1, 0, 16'h0042, '0);
    exp_q.push_back('{port: 1'b1, we: 1'b0, addr: 16'h0042, data: 16'h1234});
    repeat (2) @(posedge clock);
    #1;
    total_cnt++; if ({bus.busy, bus.mem_read} !== 2'b10) $display("FAIL stall_in_wait: got %b want 10", {bus.busy, bus.mem_read}); else pass_cnt++;
    drive_cpu(1, 0, 16'h0011, '0);
    exp_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0011, data: 16'hCAFE});
    #1;
    total_cnt++; if (bus.cpu_stall !== 1'b1) $display("FAIL stall_rise: got %b want 1", bus.cpu_stall); else pass_cnt++;
    wait_ack(who, edges);
    t = exp_q.pop_front();
    show_txn(t, edges);
    total_cnt++; if (who !== int'(t.port)) $display("FAIL stall_ext_port: got %0d want %0d", who, t.port); else pass_cnt++;
    total_cnt++; if (bus.ext_rdata !== t.data) $display("FAIL stall_ext_data: got %h want %h", bus.ext_rdata, t.data); else pass_cnt++;
    total_cnt++; if (bus.cpu_stall !== 1'b1) $display("FAIL stall_at_ext_ack: got %b want 1", bus.cpu_stall); else pass_cnt++;
    drive_ext(0, 0, '0, '0);
    @(posedge clock); #1;
    total_cnt++; if ({bus.busy, bus.mem_read, bus.cpu_stall} !== 3'b001)
      $display("FAIL stall_idle_gap: got %b want 001", {bus.busy, bus.mem_read, bus.cpu_stall}); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if ({bus.mem_read, bus.mem_addr, bus.cpu_stall} !== {1'b1, 16'h0011, 1'b1})
      $display("FAIL stall_cpu_issue: got %b %h %b want 1 0011 1", bus.mem_read, bus.mem_addr, bus.cpu_stall); else pass_cnt++;
    wait_ack(who, edges);
    t = exp_q.pop_front();
    show_txn(t, edges + 2);
    total_cnt++; if (who !== int'(t.port)) $display("FAIL stall_cpu_port: got %0d want %0d", who, t.port); else pass_cnt++;
    total_cnt++; if (edges !== 1 + RD_LAT) $display("FAIL stall_cpu_lat: got %0d want %0d", edges, 1 + RD_LAT); else pass_cnt++;
    total_cnt++; if ({bus.cpu_stall, bus.cpu_rdata} !== {1'b0, t.data})
      $display("FAIL stall_cpu_done: got %b %h want 0 %h", bus.cpu_stall, bus.cpu_rdata, t.data); else pass_cnt++;
    drive_cpu(0, 0, '0, '0);
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_wait();
    int who, edges, stray;
    txn_t t;
    drive_cpu(1, 0, 16'h0010, '0);
    repeat (2) @(posedge clock);
    #1;
    total_cnt++; if ({bus.busy, bus.mem_read} !== 2'b10) $display("FAIL rmw_in_wait: got %b want 10", {bus.busy, bus.mem_read}); else pass_cnt++;
    reset_n = 1'b0; #1;
    total_cnt++; if ({bus.busy, bus.cpu_ack, bus.cpu_rdata} !== {2'b00, 16'h0000})
      $display("FAIL rmw_reset_outputs: got %b%b %h want 00 0000", bus.busy, bus.cpu_ack, bus.cpu_rdata); else pass_cnt++;
    drive_cpu(0, 0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clock); #1;
      if (bus.cpu_ack || bus.ext_ack || bus.busy) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL rmw_no_ack: got %0d stray cycles want 0", stray); else pass_cnt++;
    drive_cpu(1, 0, 16'h0011, '0);
    exp_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0011, data: 16'hCAFE});
    wait_ack(who, edges);
    t = exp_q.pop_front();
    show_txn(t, edges);
    total_cnt++; if (who !== int'(t.port)) $display("FAIL rmw_reissue_port: got %0d want %0d", who, t.port); else pass_cnt++;
    total_cnt++; if (edges !== 2 + RD_LAT) $display("FAIL rmw_reissue_lat: got %0d want %0d", edges, 2 + RD_LAT); else pass_cnt++;
    total_cnt++; if (bus.cpu_rdata !== t.data) $display("FAIL rmw_reissue_data: got %h want %h", bus.cpu_rdata, t.data); else pass_cnt++;
    drive_cpu(0, 0, '0, '0);
    @(posedge clock); #1;
  endtask

  task automatic test_rd_lat3();
    int edges, wait_cycles;
    logic acked;
    txn_t t;
    bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = 16'h0001;
    exp_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0001, data: 16'hA5A5});
    @(posedge clock); #1;
    total_cnt++; if ({bus3.mem_read, bus3.mem_addr} !== {1'b1, 16'h0001})
      $display("FAIL lat3_issue: got %b %h want 1 0001", bus3.mem_read, bus3.mem_addr); else pass_cnt++;
    edges = 1;
    wait_cycles = 0;
    acked = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clock); #1;
      edges++;
      if (bus3.cpu_ack) begin acked = 1'b1; break; end
      if (bus3.busy && !bus3.mem_read && !bus3.mem_write) wait_cycles++;
    end
    bus3.cpu_req = 1'b0;
    t = exp_q.pop_front();
    show_txn(t, edges);
    total_cnt++; if (acked !== 1'b1) $display("FAIL lat3_ack: got %b want 1", acked); else pass_cnt++;
    total_cnt++; if (wait_cycles !== RD_LAT3) $display("FAIL lat3_wait_len: got %0d want %0d", wait_cycles, RD_LAT3); else pass_cnt++;
    total_cnt++; if (edges !== 2 + RD_LAT3) $display("FAIL lat3_lat: got %0d want %0d", edges, 2 + RD_LAT3); else pass_cnt++;
    total_cnt++; if ({bus3.cpu_rdata, bus3.ext_ack} !== {t.data, 1'b0})
      $display("FAIL lat3_data: got %h %b want %h 0", bus3.cpu_rdata, bus3.ext_ack, t.data); else pass_cnt++;
    @(posedge clock); #1;
  endtask

  initial begin
    bus3.cpu_req = 1'b0; bus3.cpu_we = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.ext_req = 1'b0; bus3.ext_we = 1'b0; bus3.ext_addr = '0; bus3.ext_wdata = '0;
    test_reset();
    test_ext_write();
    test_contention();
    test_stall();
    test_reset_mid_wait();
    test_rd_lat3();
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
